// File: rtl/daisy_chain_pkg.sv
// -----------------------------------------------------------------------------
// daisy_chain_pkg
// Shared definitions for the interrupt acknowledge daisy-chain sequencer:
// default parameter values, the FSM state encoding and a small decode helper.
// -----------------------------------------------------------------------------
package daisy_chain_pkg;

    localparam int VEC_W_DEF       = 8;
    localparam int SETTLE_CYC_DEF  = 4;
    localparam int RELEASE_CYC_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACK     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PRESENT = 3'd3,
        ST_RELEASE = 3'd4
    } seq_state_t;

    // States during which the acknowledge line into the chain is held low.
    function automatic logic ack_asserted(input seq_state_t st);
        logic res;
        case (st)
            ST_ACK, ST_CAPTURE, ST_PRESENT: res = 1'b1;
            default:                        res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/irq_ack_sequencer_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Ports:
//   clk   - sampling clock
//   rst_n - synchronous active-low reset, clears both flops
//   d     - asynchronous input level
//   q     - synchronized output level
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage resynchronization of the asynchronous input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/irq_ack_sequencer.sv
// -----------------------------------------------------------------------------
// irq_ack_sequencer
// Runs the acknowledge handshake on an interrupt daisy chain: detects a
// request, drives ACK low, lets the chain settle, captures the vector of the
// acknowledging device, presents it to the host and releases ACK.
// Ports:
//   clk          - sole clock
//   rst_n        - synchronous active-low reset
//   IRQ_chain_n  - active-low request from the chain head (asynchronous)
//   vector_in    - vector driven by the acknowledged device while ACK is low
//   int_en       - host interrupt enable, gates only new acknowledge cycles
//   host_ready   - host accepts the presented vector
//   ACK_chain_n  - active-low acknowledge into the chain head
//   int_valid    - vector valid toward the host
//   int_vector   - last captured vector
//   spurious     - one-cycle pulse when the request vanished during settle
//   busy         - high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module irq_ack_sequencer
    import daisy_chain_pkg::*;
#(
    parameter int VEC_W       = VEC_W_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int RELEASE_CYC = RELEASE_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IRQ_chain_n,
    input  logic [VEC_W-1:0] vector_in,
    input  logic             int_en,
    input  logic             host_ready,
    output logic             ACK_chain_n,
    output logic             int_valid,
    output logic [VEC_W-1:0] int_vector,
    output logic             spurious,
    output logic             busy
);

    seq_state_t       state_r;
    logic [3:0]       cnt_r;
    logic             ack_chain_n_r;
    logic             int_valid_r;
    logic [VEC_W-1:0] int_vector_r;
    logic             spurious_r;
    logic             busy_r;
    logic             irq_s;

    // The request is active-low on the chain; synchronize it as active-high.
    sync_2ff u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (~IRQ_chain_n),
        .q     (irq_s)
    );

    // Sequencer FSM with settle/release counter, capture register and outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 4'd0;
            ack_chain_n_r <= 1'b1;
            int_valid_r   <= 1'b0;
            int_vector_r  <= {VEC_W{1'b0}};
            spurious_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            spurious_r    <= 1'b0;
            // ACK is a registered decode of the current state, so it trails
            // the IDLE decision by one cycle; the settle count is aligned to it.
            ack_chain_n_r <= ~ack_asserted(state_r);
            case (state_r)
                ST_IDLE: begin
                    if (irq_s && int_en) begin
                        state_r <= ST_ACK;
                        cnt_r   <= 4'd0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_ACK: begin
                    // A vanished request wins over a completing count.
                    if (!irq_s) begin
                        state_r    <= ST_RELEASE;
                        cnt_r      <= 4'd0;
                        spurious_r <= 1'b1;
                    end else if (cnt_r == 4'(SETTLE_CYC - 1)) begin
                        state_r <= ST_CAPTURE;
                        cnt_r   <= 4'd0;
                    end else begin
                        cnt_r   <= cnt_r + 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    int_vector_r <= vector_in;
                    int_valid_r  <= 1'b1;
                    state_r      <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (host_ready) begin
                        int_valid_r <= 1'b0;
                        state_r     <= ST_RELEASE;
                        cnt_r       <= 4'd0;
                    end else begin
                        int_valid_r <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_r == 4'(RELEASE_CYC - 1)) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 4'd0;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= 4'd0;
                    int_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign ACK_chain_n = ack_chain_n_r;
    assign int_valid   = int_valid_r;
    assign int_vector  = int_vector_r;
    assign spurious    = spurious_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_irq_ack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_irq_ack_sequencer
// Scoreboard bench: stimulus queues the expected outcome of every acknowledge
// cycle (a vector or a spurious event); an independent monitor pops and
// compares whenever the DUT hands a vector to the host or pulses spurious.
// -----------------------------------------------------------------------------
module tb_irq_ack_sequencer;

    localparam int VEC_W       = 8;
    localparam int SETTLE_CYC  = 4;
    localparam int RELEASE_CYC = 2;
    localparam int SPACING     = SETTLE_CYC + 1 + 1 + RELEASE_CYC + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             IRQ_chain_n = 1'b1;
    logic [VEC_W-1:0] vector_in = 8'h00;
    logic             int_en = 1'b1;
    logic             host_ready = 1'b0;
    logic             ACK_chain_n;
    logic             int_valid;
    logic [VEC_W-1:0] int_vector;
    logic             spurious;
    logic             busy;

    typedef struct {
        bit               spur;
        logic [VEC_W-1:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   spur_seen = 0;
    bit   hr_rand = 1'b0;
    bit   hr_fixed = 1'b1;

    irq_ack_sequencer #(
        .VEC_W       (VEC_W),
        .SETTLE_CYC  (SETTLE_CYC),
        .RELEASE_CYC (RELEASE_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .IRQ_chain_n (IRQ_chain_n),
        .vector_in   (vector_in),
        .int_en      (int_en),
        .host_ready  (host_ready),
        .ACK_chain_n (ACK_chain_n),
        .int_valid   (int_valid),
        .int_vector  (int_vector),
        .spurious    (spurious),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // Cycle counter used for spacing measurements.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Host ready driver: fixed level or random, changed just after each edge.
    initial forever begin
        @(posedge clk);
        #1;
        host_ready = hr_rand ? 1'($urandom_range(0, 1)) : hr_fixed;
    end

    // Monitor: pops the scoreboard on every host handshake or spurious pulse.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (spurious) begin
                spur_seen++;
                chk("spur_valid_low", int'(int_valid), 0);
                if (exp_q.size() == 0) begin
                    chk("spur_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("spur_kind", int'(e.spur), 1);
                end
            end
            if (int_valid) begin
                chk("valid_ack_low", int'(ACK_chain_n), 0);
            end
            if (int_valid && host_ready) begin
                if (exp_q.size() == 0) begin
                    chk("vec_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("vec_kind", int'(e.spur), 0);
                    chk("vec_value", int'(int_vector), int'(e.vec));
                end
            end
        end
    end

    task automatic wait_ack_low(input string name);
        int n = 0;
        while (ACK_chain_n !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk(name, n, -1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (int_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk(name, n, -1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk(name, n, -1);
    endtask

    // One acknowledge cycle; spur releases the request right after ACK falls.
    task automatic do_txn(input logic [VEC_W-1:0] v, input bit spur, input bit en_drop);
        vector_in   = v;
        IRQ_chain_n = 1'b0;
        wait_ack_low("txn_ack_timeout");
        exp_q.push_back('{spur, v});
        if (spur) begin
            IRQ_chain_n = 1'b1;
        end else begin
            wait_valid("txn_valid_timeout");
            if (en_drop) int_en = 1'b0;
            IRQ_chain_n = 1'b1;
        end
        wait_idle("txn_idle_timeout");
        int_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int t_prev;
        int t_now;
        logic [VEC_W-1:0] vals [3];

        // Reset held 3 cycles with a pending request.
        IRQ_chain_n = 1'b0;
        rst_n       = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ack", int'(ACK_chain_n), 1);
            chk("rst_valid", int'(int_valid), 0);
            chk("rst_busy", int'(busy), 0);
        end
        chk("rst_vector", int'(int_vector), 0);
        chk("rst_spurious", int'(spurious), 0);
        IRQ_chain_n = 1'b1;
        rst_n       = 1'b1;
        repeat (4) @(negedge clk);

        // Single request: latency, one-cycle presentation, ACK released.
        vector_in   = 8'hA5;
        hr_fixed    = 1'b1;
        IRQ_chain_n = 1'b0;
        n = 0;
        while (ACK_chain_n !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("irq_to_ack_latency", n, 4);
        exp_q.push_back('{1'b0, 8'hA5});
        wait_valid("single_valid_timeout");
        n = 0;
        while (int_valid === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("single_valid_width", n, 1);
        IRQ_chain_n = 1'b1;
        wait_idle("single_idle_timeout");
        chk("single_ack_released", int'(ACK_chain_n), 1);

        // Spurious: request withdrawn while ACK settles.
        n = spur_seen;
        IRQ_chain_n = 1'b0;
        vector_in   = 8'h11;
        wait_ack_low("spur_ack_timeout");
        exp_q.push_back('{1'b1, 8'h00});
        IRQ_chain_n = 1'b1;
        t_now = 0;
        while (spurious !== 1'b1 && t_now < 40) begin
            @(negedge clk);
            t_now++;
        end
        chk("spur_pulse_seen", int'(spurious), 1);
        t_now = 0;
        while (busy === 1'b1 && t_now < 40) begin
            @(negedge clk);
            t_now++;
        end
        chk("spur_release_len", t_now, RELEASE_CYC);
        repeat (3) @(negedge clk);
        chk("spur_pulse_count", spur_seen - n, 1);

        // Host stall for 20 cycles; request and enable dropped meanwhile.
        hr_fixed    = 1'b0;
        vector_in   = 8'h3C;
        IRQ_chain_n = 1'b0;
        wait_ack_low("stall_ack_timeout");
        exp_q.push_back('{1'b0, 8'h3C});
        wait_valid("stall_valid_timeout");
        IRQ_chain_n = 1'b1;
        int_en      = 1'b0;
        vector_in   = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            chk("stall_valid", int'(int_valid), 1);
            chk("stall_ack", int'(ACK_chain_n), 0);
            chk("stall_vector", int'(int_vector), 8'h3C);
            @(negedge clk);
        end
        hr_fixed = 1'b1;
        wait_idle("stall_idle_timeout");
        chk("stall_retain_vector", int'(int_vector), 8'h3C);
        int_en = 1'b1;
        @(negedge clk);

        // Masking: request pending with interrupts disabled.
        int_en      = 1'b0;
        IRQ_chain_n = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("mask_ack", int'(ACK_chain_n), 1);
            chk("mask_busy", int'(busy), 0);
        end
        IRQ_chain_n = 1'b1;
        repeat (3) @(negedge clk);
        int_en = 1'b1;

        // Enable dropped during PRESENT completes normally.
        hr_fixed = 1'b0;
        vector_in   = 8'h5A;
        IRQ_chain_n = 1'b0;
        wait_ack_low("endrop_ack_timeout");
        exp_q.push_back('{1'b0, 8'h5A});
        wait_valid("endrop_valid_timeout");
        int_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("endrop_still_valid", int'(int_valid), 1);
        hr_fixed    = 1'b1;
        IRQ_chain_n = 1'b1;
        wait_idle("endrop_idle_timeout");
        chk("endrop_queue_empty", exp_q.size(), 0);
        int_en = 1'b1;

        // Mid-cycle reset in PRESENT.
        hr_fixed    = 1'b0;
        vector_in   = 8'h77;
        IRQ_chain_n = 1'b0;
        wait_ack_low("mrst_ack_timeout");
        wait_valid("mrst_valid_timeout");
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_ack", int'(ACK_chain_n), 1);
        chk("mrst_valid", int'(int_valid), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_vector", int'(int_vector), 0);
        exp_q.delete();

        // Back-to-back requests after reset with the request held low.
        hr_fixed = 1'b1;
        vals[0] = 8'h81;
        vals[1] = 8'h42;
        vals[2] = 8'hE7;
        vector_in = vals[0];
        rst_n = 1'b1;
        n = 0;
        while (ACK_chain_n !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_latency", n, 4);
        t_prev = cyc;
        exp_q.push_back('{1'b0, vals[0]});
        for (int k = 1; k < 3; k++) begin
            n = 0;
            while (ACK_chain_n !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            vector_in = vals[k];
            wait_ack_low("b2b_ack_timeout");
            t_now = cyc;
            exp_q.push_back('{1'b0, vals[k]});
            chk("b2b_spacing", t_now - t_prev, SPACING);
            t_prev = t_now;
        end
        wait_valid("b2b_valid_timeout");
        IRQ_chain_n = 1'b1;
        wait_idle("b2b_idle_timeout");
        repeat (3) @(negedge clk);
        chk("b2b_queue_empty", exp_q.size(), 0);

        // Randomized traffic with a random host.
        hr_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            do_txn(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
        hr_rand  = 1'b0;
        hr_fixed = 1'b1;
        repeat (5) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_idle", int'(busy), 0);
        chk("final_ack", int'(ACK_chain_n), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #400000;
        $display("FAIL timeout actual=%0d required=0", cyc);
        $fatal(1, "time limit");
    end

endmodule
